// File: rtl/load_store_unit.sv
// Load/store unit: one aligned data-memory transaction per request
// on a word-wide req/gnt/rvalid bus, with load formatting and timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_e;

    localparam logic [CNT_WIDTH-1:0] TO = CNT_WIDTH'(TIMEOUT_CYCLES);

    state_e                state_q, state_d;
    logic [31:0]           addr_q, wdata_q, rdata_q, rdata_d;
    logic [2:0]            op_q;
    logic                  we_q, err_q, err_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
    logic                  accept, bad, expire;
    logic [1:0]            off;
    logic [31:0]           shifted, fmt;
    logic [3:0]            be_f;
    logic [31:0]           wd_f;

    assign accept  = req_valid && (state_q == IDLE);
    assign off     = addr_q[1:0];
    assign cnt_inc = cnt_q + 1'b1;
    assign expire  = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO);

    always_comb begin
        bad = 1'b0;
        if (req_read == req_write) begin
            bad = 1'b1;
        end else if (req_read) begin
            bad = (req_op == 3'b011) || (req_op[2:1] == 2'b11);
        end else begin
            bad = (req_op[2] == 1'b1) || (req_op[1:0] == 2'b11);
        end
        if (req_op[1:0] == 2'b01 && req_addr[0])
            bad = 1'b1;
        if (req_op[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
            bad = 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state; a gnt/rvalid in the expiry cycle wins over the timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (accept) state_d = bad ? RESP : REQ;
            REQ: begin
                if (mem_gnt)     state_d = we_q ? RESP : WAIT_R;
                else if (expire) state_d = RESP;
            end
            WAIT_R: if (mem_rvalid || expire) state_d = RESP;
            RESP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        be_f = 4'b1111;
        wd_f = wdata_q;
        case (op_q[1:0])
            2'b00: begin
                be_f = 4'b0001 << off;
                wd_f = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_f = 4'b0011 << off;
                wd_f = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        mem_req    = (state_q == REQ);
        mem_we     = mem_req && we_q;
        mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_be     = mem_req ? be_f : 4'h0;
        mem_wdata  = mem_we ? wd_f : 32'h0;
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

    always_comb begin
        shifted = mem_rdata >> {off, 3'b000};
        case (op_q)
            3'b000:  fmt = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  fmt = {24'h0, shifted[7:0]};
            3'b001:  fmt = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  fmt = {16'h0, shifted[15:0]};
            default: fmt = shifted;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept && bad) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end
            end
            REQ: begin
                cnt_d = mem_gnt ? '0 : cnt_inc;
                if (mem_gnt && we_q) begin
                    err_d   = 1'b0;
                    rdata_d = 32'h0;
                end else if (!mem_gnt && expire) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end
            end
            WAIT_R: begin
                cnt_d = cnt_inc;
                if (mem_rvalid) begin
                    err_d   = 1'b0;
                    rdata_d = fmt;
                end else if (expire) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            op_q    <= 3'b000;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                op_q    <= req_op;
                we_q    <= req_write;
            end
        end
    end

endmodule
